// File: rtl/dispatch_pkg.sv
// Shared types and constants for the instruction dispatch queue.
package dispatch_pkg;

   localparam int DISPATCH_INST_W = 26;
   localparam logic [DISPATCH_INST_W-1:0] DISPATCH_NOP = 26'h0500000;

   typedef logic [DISPATCH_INST_W-1:0] inst_t;

   typedef enum logic {
      PIPE_SCALAR = 1'b0,
      PIPE_VECTOR = 1'b1
   } pipe_id_e;

endpackage

// File: rtl/dispatch_fifo.sv
// Per-pipe instruction FIFO with wrap-bit pointers, no fall-through, no bypass.
module dispatch_fifo
   import dispatch_pkg::*;
#(
   parameter int INST_W = DISPATCH_INST_W,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [INST_W-1:0] push_data,
   input  logic              pop,
   output logic [INST_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr, rd_ptr;
   logic [INST_W-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset and flush both drop every entry.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/inst_dispatch_queue.sv
// Routes fetched instructions into per-pipe FIFOs; idle pipes show NOP.
// Optional perf counters enabled by defining DISPATCH_PERF_CNT_EN.
module inst_dispatch_queue
   import dispatch_pkg::*;
#(
   parameter int                INST_W    = DISPATCH_INST_W,
   parameter int                NUM_PIPES = 2,
   parameter int                DEPTH     = 2,
   parameter logic [INST_W-1:0] NOP_INST  = INST_W'(DISPATCH_NOP),
   parameter int                SEL_W     = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        in_valid,
   input  logic [INST_W-1:0]           in_inst,
   input  logic [SEL_W-1:0]            in_sel,
   output logic                        in_ready,
   output logic [NUM_PIPES-1:0]        out_valid,
   output logic [NUM_PIPES*INST_W-1:0] out_inst,
   input  logic [NUM_PIPES-1:0]        out_ready,
   output logic                        sel_err
`ifdef DISPATCH_PERF_CNT_EN
   ,
   output logic [NUM_PIPES*32-1:0]     perf_disp,
   output logic [31:0]                 perf_stall
`endif
);

   logic [NUM_PIPES-1:0]             full, empty, push, pop;
   logic [NUM_PIPES-1:0][INST_W-1:0] head;
   logic                             sel_ok, sel_full, accept;

   // Select decode: out-of-range selects never look full so they drain.
   always_comb begin
      sel_ok   = (int'(in_sel) < NUM_PIPES);
      sel_full = 1'b0;
      for (int p = 0; p < NUM_PIPES; p++)
         if (in_sel == SEL_W'(p))
            sel_full = full[p];
   end

   assign in_ready = rst_n && !flush && !sel_full;
   assign accept   = in_valid && in_ready;

   for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
      assign push[p] = accept && (in_sel == SEL_W'(p));
      assign pop[p]  = out_ready[p] && !empty[p] && !flush && rst_n;

      dispatch_fifo #(
         .INST_W (INST_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .push      (push[p]),
         .push_data (in_inst),
         .pop       (pop[p]),
         .head      (head[p]),
         .full      (full[p]),
         .empty     (empty[p])
      );

      assign out_valid[p]                  = !empty[p];
      assign out_inst[p*INST_W +: INST_W]  = empty[p] ? NOP_INST : head[p];
   end

   // Sticky bad-select flag; only reset clears it, flush keeps it.
   always_ff @(posedge clk) begin
      if (!rst_n)
         sel_err <= 1'b0;
      else if (accept && !sel_ok)
         sel_err <= 1'b1;
   end

`ifdef DISPATCH_PERF_CNT_EN
   // Free-running pop and stall counters, wrap at 2^32, cleared by reset only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_disp  <= '0;
         perf_stall <= '0;
      end else begin
         for (int p = 0; p < NUM_PIPES; p++)
            if (pop[p])
               perf_disp[p*32 +: 32] <= perf_disp[p*32 +: 32] + 32'd1;
         if (in_valid && !in_ready)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_inst_dispatch_queue.sv
// Directed table-driven bench for inst_dispatch_queue (2-pipe and 3-pipe builds).
module tb_inst_dispatch_queue;
   import dispatch_pkg::*;

   localparam inst_t N = 26'h0500000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 2-pipe instance
   logic        rst_n, flush, in_valid, in_ready, sel_err;
   inst_t       in_inst;
   logic [0:0]  in_sel;
   logic [1:0]  out_valid, out_ready;
   logic [51:0] out_inst;
`ifdef DISPATCH_PERF_CNT_EN
   logic [63:0] perf_disp;
   logic [31:0] perf_stall;
   logic [95:0] perf_disp3;
   logic [31:0] perf_stall3;
`endif

   // 3-pipe instance
   logic        flush3, in_valid3, in_ready3, sel_err3;
   inst_t       in_inst3;
   logic [1:0]  in_sel3;
   logic [2:0]  out_valid3, out_ready3;
   logic [77:0] out_inst3;

   inst_dispatch_queue #(.NUM_PIPES(2), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_inst(in_inst), .in_sel(in_sel), .in_ready(in_ready),
      .out_valid(out_valid), .out_inst(out_inst), .out_ready(out_ready),
      .sel_err(sel_err)
`ifdef DISPATCH_PERF_CNT_EN
      , .perf_disp(perf_disp), .perf_stall(perf_stall)
`endif
   );

   inst_dispatch_queue #(.NUM_PIPES(3), .DEPTH(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .flush(flush3), .in_valid(in_valid3),
      .in_inst(in_inst3), .in_sel(in_sel3), .in_ready(in_ready3),
      .out_valid(out_valid3), .out_inst(out_inst3), .out_ready(out_ready3),
      .sel_err(sel_err3)
`ifdef DISPATCH_PERF_CNT_EN
      , .perf_disp(perf_disp3), .perf_stall(perf_stall3)
`endif
   );

   typedef struct {
      logic       rst_n, flush, vld;
      inst_t      inst;
      logic [0:0] sel;
      logic [1:0] ordy;
      logic       e_rdy;
      logic [1:0] e_ov;
      inst_t      e_p0, e_p1;
      logic       e_err;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, f, v, input inst_t i, input logic [0:0] s,
                               input logic [1:0] o, input logic er, input logic [1:0] eov,
                               input inst_t p0, p1, input logic ee);
      vec_t t;
      t.rst_n = r; t.flush = f; t.vld = v; t.inst = i; t.sel = s; t.ordy = o;
      t.e_rdy = er; t.e_ov = eov; t.e_p0 = p0; t.e_p1 = p1; t.e_err = ee;
      return t;
   endfunction

   vec_t tv[19];

   initial begin
      // Expected values describe state before the vector's clock edge.
      //          rst flu vld inst          sel  ordy   rdy  ov     p0            p1            err
      tv[0]  = mk(0, 0, 1, 26'h0000111, 1'b0, 2'b00, 0, 2'b00, N,            N,            0);
      tv[1]  = mk(1, 0, 1, 26'h0000123, 1'b0, 2'b00, 1, 2'b00, N,            N,            0);
      tv[2]  = mk(1, 0, 1, 26'h3ABCDEF, 1'b1, 2'b00, 1, 2'b01, 26'h0000123, N,            0);
      tv[3]  = mk(1, 0, 0, 26'h0000000, 1'b0, 2'b00, 1, 2'b11, 26'h0000123, 26'h3ABCDEF, 0);
      tv[4]  = mk(1, 0, 1, 26'h0000456, 1'b0, 2'b01, 1, 2'b11, 26'h0000123, 26'h3ABCDEF, 0);
      tv[5]  = mk(1, 0, 0, 26'h0000000, 1'b0, 2'b00, 1, 2'b11, 26'h0000456, 26'h3ABCDEF, 0);
      tv[6]  = mk(1, 1, 1, 26'h0000777, 1'b0, 2'b11, 0, 2'b11, 26'h0000456, 26'h3ABCDEF, 0);
      tv[7]  = mk(1, 0, 0, 26'h0000000, 1'b0, 2'b00, 1, 2'b00, N,            N,            0);
      tv[8]  = mk(1, 0, 1, 26'h0000A01, 1'b1, 2'b00, 1, 2'b00, N,            N,            0);
      tv[9]  = mk(1, 0, 1, 26'h0000A02, 1'b1, 2'b00, 1, 2'b10, N,            26'h0000A01, 0);
      tv[10] = mk(1, 0, 1, 26'h0000A03, 1'b1, 2'b00, 0, 2'b10, N,            26'h0000A01, 0);
      tv[11] = mk(1, 0, 1, 26'h0000A03, 1'b1, 2'b10, 0, 2'b10, N,            26'h0000A01, 0);
      tv[12] = mk(1, 0, 1, 26'h0000A03, 1'b1, 2'b10, 1, 2'b10, N,            26'h0000A02, 0);
      tv[13] = mk(1, 0, 0, 26'h0000000, 1'b1, 2'b10, 1, 2'b10, N,            26'h0000A03, 0);
      tv[14] = mk(1, 0, 0, 26'h0000000, 1'b1, 2'b10, 1, 2'b00, N,            N,            0);
      tv[15] = mk(1, 0, 1, 26'h0000B01, 1'b0, 2'b01, 1, 2'b00, N,            N,            0);
      tv[16] = mk(1, 0, 0, 26'h0000000, 1'b0, 2'b00, 1, 2'b01, 26'h0000B01, N,            0);
      tv[17] = mk(0, 0, 1, 26'h0000C01, 1'b0, 2'b00, 0, 2'b01, 26'h0000B01, N,            0);
      tv[18] = mk(1, 0, 0, 26'h0000000, 1'b0, 2'b00, 1, 2'b00, N,            N,            0);

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_inst = '0; in_sel = '0; out_ready = '0;
      flush3 = 1'b0; in_valid3 = 1'b0; in_inst3 = '0; in_sel3 = '0; out_ready3 = '0;

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         rst_n = tv[i].rst_n; flush = tv[i].flush; in_valid = tv[i].vld;
         in_inst = tv[i].inst; in_sel = tv[i].sel; out_ready = tv[i].ordy;
         #1;
         chk($sformatf("v%0d in_ready", i),  80'(in_ready),       80'(tv[i].e_rdy));
         chk($sformatf("v%0d out_valid", i), 80'(out_valid),      80'(tv[i].e_ov));
         chk($sformatf("v%0d pipe0", i),     80'(out_inst[25:0]), 80'(tv[i].e_p0));
         chk($sformatf("v%0d pipe1", i),     80'(out_inst[51:26]),80'(tv[i].e_p1));
         chk($sformatf("v%0d sel_err", i),   80'(sel_err),        80'(tv[i].e_err));
      end

      // Bad select on the 3-pipe build
      @(negedge clk);
      in_valid = 1'b0;
      in_valid3 = 1'b1; in_sel3 = 2'd3; in_inst3 = 26'h0000999;
      #1;
      chk("bad_sel in_ready", 80'(in_ready3), 80'(1));
      chk("bad_sel err_pre",  80'(sel_err3),  80'(0));
      @(negedge clk);
      in_sel3 = 2'd2; in_inst3 = 26'h0000222;
      #1;
      chk("bad_sel err_set",  80'(sel_err3),   80'(1));
      chk("bad_sel dropped",  80'(out_valid3), 80'(3'b000));
      @(negedge clk);
      in_valid3 = 1'b0;
      #1;
      chk("pipe2 valid", 80'(out_valid3),        80'(3'b100));
      chk("pipe2 inst",  80'(out_inst3[77:52]),  80'(26'h0000222));
      chk("pipe0 nop",   80'(out_inst3[25:0]),   80'(N));
      @(negedge clk);
      flush3 = 1'b1; in_valid3 = 1'b1; in_sel3 = 2'd3;
      #1;
      chk("flush3 in_ready", 80'(in_ready3), 80'(0));
      @(negedge clk);
      flush3 = 1'b0; in_valid3 = 1'b0;
      #1;
      chk("flush3 err_kept", 80'(sel_err3),   80'(1));
      chk("flush3 emptied",  80'(out_valid3), 80'(3'b000));
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset clears err", 80'(sel_err3), 80'(0));

`ifdef DISPATCH_PERF_CNT_EN
      // Five pushes to pipe 0, each popped the following cycle
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_sel = 1'b0; in_inst = inst_t'(26'h0000D00 + k); out_ready = 2'b01;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("perf_disp0",  80'(perf_disp[31:0]),  80'(5));
      chk("perf_disp1",  80'(perf_disp[63:32]), 80'(0));
      chk("perf_stall0", 80'(perf_stall),       80'(0));
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("perf_stall1",  80'(perf_stall),      80'(1));
      chk("perf_disp_kept", 80'(perf_disp[31:0]), 80'(5));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_dispatch_queue.md
Name: inst_dispatch_queue

Overview:
- Parametrised, registered successor to the combinational scalar/vector instruction selector.
- Routes each fetched instruction to one of NUM_PIPES execution pipes (pipe 0 = scalar, pipe 1 = vector by default) through a per-pipe FIFO, with valid/ready handshakes on both sides.
- Every idle pipe output carries the NOP encoding, so downstream decode always sees a legal instruction.
- Sits between fetch and the per-pipe decode stages.

Parameters:
- INST_W, 26, instruction width in bits.
- NUM_PIPES, 2, number of destination pipes (2..8).
- DEPTH, 2, entries per pipe FIFO (power of two, 2..16).
- NOP_INST, 26'h0500000, encoding driven on an idle pipe output (zero-extended to INST_W).
- SEL_W, $clog2(NUM_PIPES) (minimum 1), width of the pipe select.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous flush; drops all queued instructions.
- in_valid  in  1  fetch presents an instruction.
- in_inst  in  INST_W  instruction.
- in_sel  in  SEL_W  destination pipe index.
- in_ready  out  1  dispatcher accepts this cycle.
- out_valid  out  NUM_PIPES  per-pipe head valid.
- out_inst  out  NUM_PIPES*INST_W  per-pipe head instruction, packed; pipe p occupies bits [p*INST_W +: INST_W].
- out_ready  in  NUM_PIPES  per-pipe consumer ready.
- sel_err  out  1  sticky flag: an instruction with in_sel >= NUM_PIPES was accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All FIFOs empty.
  - out_valid = 0, out_inst = NOP_INST on every pipe.
  - sel_err = 0, in_ready = 0 during the reset cycle.
- Accept: a transfer occurs when in_valid && in_ready at the clk edge.
  - in_ready = !flush && !full[in_sel] for a valid in_sel.
  - For in_sel >= NUM_PIPES: in_ready = !flush, the instruction is discarded and sel_err sets. sel_err clears only on reset.
- Latency: an accepted instruction appears at out_valid/out_inst of its pipe the next cycle if the FIFO was empty. Otherwise it appears after the older entries drain. No combinational in->out path.
- Output pipe p:
  - out_valid[p] = FIFO p non-empty.
  - out_inst[p] = head entry when non-empty, NOP_INST when empty.
  - Pop when out_valid[p] && out_ready[p].
- Ordering:
  - FIFO order is preserved per pipe.
  - No ordering is guaranteed across pipes; inter-pipe hazards are the issue logic's responsibility.
- Simultaneous push and pop on the same pipe:
  - Both take effect; the count is unchanged.
  - Push to a full FIFO is impossible because in_ready is low, even if a pop happens the same cycle (no bypass of full).
  - Push to an empty FIFO with out_ready high: the entry becomes visible next cycle (no fall-through).
- Pointers: rd/wr pointers are log2(DEPTH)+1 bits with wrap bit.
  - full = MSBs differ and LSBs equal.
  - empty = pointers equal.
  - Pointers wrap modulo 2*DEPTH.
- Flush:
  - All pointers are reset at the clk edge; the next cycle shows out_valid = 0 and NOP outputs.
  - in_ready = 0 during flush; pops in that cycle are ignored.
  - sel_err is retained.
- out_ready on an empty pipe has no effect.
- Reset asserted mid-operation discards all contents identically to flush and additionally clears sel_err.

Optional Feature:
- Macro DISPATCH_PERF_CNT_EN.
- Defined:
  - Adds output perf_disp (NUM_PIPES*32): per-pipe count of popped instructions.
  - Adds output perf_stall (32): cycles with in_valid && !in_ready.
  - Counters clear on reset only (not on flush) and wrap at 2^32.
- Undefined: these ports and their registers do not exist.

Decomposition:
- Package dispatch_pkg:
  - INST_W default.
  - NOP_INST constant.
  - Typedef inst_t (logic [INST_W-1:0]).
  - Enum pipe_id_e {PIPE_SCALAR=0, PIPE_VECTOR=1}.
- Sub-module dispatch_fifo (parameters INST_W, DEPTH): one per pipe, instantiated with a generate loop.
  - Ports: clk, rst_n, flush, push, push_data, pop, head, full, empty.
- The top level holds select decode, ready muxing, NOP substitution, sel_err and the optional counters.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=2'b00, both out_inst=26'h0500000, sel_err=0.
- Routing: push 26'h0000123 (sel 0) then 26'h3ABCDEF (sel 1), out_ready=0 -> cycle+1: out_valid=2'b01 with pipe0=26'h0000123 and pipe1=NOP. Cycle+2: out_valid=2'b11 with pipe1=26'h3ABCDEF.
- Full/backpressure, DEPTH=2: push 3 instructions to pipe 1 with out_ready[1]=0 -> third sees in_ready=0. Raise out_ready[1] -> pops in order 1st, 2nd, then the third is accepted and popped.
- Simultaneous push/pop: pipe 0 holding 1 entry, push and pop in the same cycle -> count stays 1, head advances to the new instruction, out_valid[0] stays 1.
- Flush: both FIFOs non-empty, pulse flush -> next cycle out_valid=0, NOP outputs, in_ready=0 during the flush cycle.
- Bad select, NUM_PIPES=3: push with in_sel=3 -> accepted and dropped, sel_err=1 persisting through a flush, cleared by reset.
- With DISPATCH_PERF_CNT_EN defined: pop 5 instructions from pipe 0 -> perf_disp[31:0]=5.
